store_buffer: RTL and testbench

- Small in-order FIFO between the execute/memory-stage pipeline register and the byte-addressed data memory.
- Accepts stores from the pipeline and retires them to the memory write port in cycles when no load needs the shared address port.
- Stalls loads that hit a word with a pending store, so loads always observe program-order data.
- Drives the data memory's address, write-data, funct3, load-enable and store-enable inputs.

---
 rtl/core_pkg.sv | 26 ++
 rtl/store_buffer_if.sv | 43 ++++
 rtl/store_align_check.sv | 27 ++
 rtl/store_buffer.sv | 108 ++++++++++
 tb/tb_store_buffer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions for the memory stage: funct3 encodings, the XLEN
// constant and the store-buffer entry layout.
package core_pkg;

  localparam int unsigned XLEN = 32;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One buffered store: {addr, data, funct3}
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      funct3;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side and memory-side signals of the store buffer.
//   master : pipeline / test driver (drives st_* and ld_* requests)
//   slave  : store_buffer (drives ready/stall/misalign, empty and mem_*)
interface store_buffer_if;
  import core_pkg::*;

  logic            st_valid_i;
  logic [XLEN-1:0] st_addr_i;
  logic [XLEN-1:0] st_data_i;
  logic [2:0]      st_funct3_i;
  logic            st_ready_o;
  logic            st_misalign_o;

  logic            ld_valid_i;
  logic [XLEN-1:0] ld_addr_i;
  logic [2:0]      ld_funct3_i;
  logic            ld_stall_o;

  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [2:0]      mem_funct3_o;
  logic            mem_load_o;
  logic            mem_store_o;

  logic            empty_o;

  modport master (
    output st_valid_i, st_addr_i, st_data_i, st_funct3_i,
    output ld_valid_i, ld_addr_i, ld_funct3_i,
    input  st_ready_o, st_misalign_o, ld_stall_o,
    input  mem_addr_o, mem_wdata_o, mem_funct3_o, mem_load_o, mem_store_o,
    input  empty_o
  );

  modport slave (
    input  st_valid_i, st_addr_i, st_data_i, st_funct3_i,
    input  ld_valid_i, ld_addr_i, ld_funct3_i,
    output st_ready_o, st_misalign_o, ld_stall_o,
    output mem_addr_o, mem_wdata_o, mem_funct3_o, mem_load_o, mem_store_o,
    output empty_o
  );

endinterface

// File: rtl/store_align_check.sv
// Combinational funct3/alignment legality check for memory accesses.
//   addr_lo : low two bits of the byte address
//   funct3  : access funct3
//   is_load : 1 = judge as a load (also accepts LBU/LHU), 0 = as a store
//   ok      : access is legal and naturally aligned
module store_align_check
  import core_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] funct3,
  input  logic       is_load,
  output logic       ok
);

  always_comb begin
    ok = 1'b0;
    case (funct3)
      F3_SB:   ok = 1'b1;
      F3_SH:   ok = ~addr_lo[0];
      F3_SW:   ok = (addr_lo == 2'b00);
      F3_LBU:  ok = is_load;
      F3_LHU:  ok = is_load & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the EX/MEM pipeline register and a
// single-ported byte-addressed data memory. Loads own the port whenever
// they can go; buffered stores retire in every other cycle. A load that
// hits a word with a pending store stalls until that store has drained.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   sb           : store_buffer_if.slave (store/load requests, mem port,
//                  ready/stall/misalign/empty status)
module store_buffer
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  store_buffer_if.slave sb
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  sb_entry_t        fifo_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic             misalign_q;

  logic             st_ok;
  logic             st_ready;
  logic             enq;
  logic             hit;
  logic             ld_grant;
  logic             drain;
  logic [PTR_W-1:0] off;

  store_align_check u_align (
    .addr_lo (sb.st_addr_i[1:0]),
    .funct3  (sb.st_funct3_i),
    .is_load (1'b0),
    .ok      (st_ok)
  );

  assign st_ready = (count_q != FULL);
  assign enq      = sb.st_valid_i & st_ready & st_ok;

  // An entry is live when its distance from head is below count.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - head_q;
      if (({1'b0, off} < count_q) &&
          (fifo_q[i].addr[XLEN-1:2] == sb.ld_addr_i[XLEN-1:2]))
        hit = 1'b1;
    end
  end

  assign ld_grant = sb.ld_valid_i & ~hit;
  assign drain    = ~ld_grant & (count_q != '0);

  always_comb begin
    sb.mem_addr_o   = '0;
    sb.mem_wdata_o  = '0;
    sb.mem_funct3_o = '0;
    sb.mem_load_o   = 1'b0;
    sb.mem_store_o  = 1'b0;
    if (ld_grant) begin
      sb.mem_addr_o   = sb.ld_addr_i;
      sb.mem_funct3_o = sb.ld_funct3_i;
      sb.mem_load_o   = 1'b1;
    end else if (drain) begin
      sb.mem_addr_o   = fifo_q[head_q].addr;
      sb.mem_wdata_o  = fifo_q[head_q].data;
      sb.mem_funct3_o = fifo_q[head_q].funct3;
      sb.mem_store_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (enq)   tail_q <= tail_q + 1'b1;
      if (drain) head_q <= head_q + 1'b1;
      case ({enq, drain})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Full-buffer stores are held by the pipeline, not rejected.
      misalign_q <= sb.st_valid_i & st_ready & ~st_ok;
    end
  end

  // Payload storage has no reset; validity comes from head/count.
  always_ff @(posedge clk_i) begin
    if (enq)
      fifo_q[tail_q] <= '{addr: sb.st_addr_i, data: sb.st_data_i, funct3: sb.st_funct3_i};
  end

  assign sb.st_ready_o    = st_ready;
  assign sb.st_misalign_o = misalign_q;
  assign sb.ld_stall_o    = sb.ld_valid_i & hit;
  assign sb.empty_o       = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if sbif ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb    (sbif.slave)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  ent_t q[$];
  logic exp_mis = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [2:0] f, input logic [31:0] a);
    case (f)
      3'd0:    return 1'b1;
      3'd1:    return a[0] == 1'b0;
      3'd2:    return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // One cycle: drive, check outputs mid-cycle against the queue model,
  // then advance the model at the clock edge.
  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [2:0] sf, input logic lv, input logic [31:0] la,
                      input logic [2:0] lf);
    logic e_ready, e_legal, e_hit, e_grant, e_drain;
    sbif.st_valid_i  = sv;
    sbif.st_addr_i   = sa;
    sbif.st_data_i   = sd;
    sbif.st_funct3_i = sf;
    sbif.ld_valid_i  = lv;
    sbif.ld_addr_i   = la;
    sbif.ld_funct3_i = lf;
    @(negedge clk);
    e_ready = (q.size() != DEPTH);
    e_legal = legal(sf, sa);
    e_hit   = 1'b0;
    foreach (q[k]) if (q[k].a[31:2] == la[31:2]) e_hit = 1'b1;
    e_grant = lv && !e_hit;
    e_drain = !e_grant && (q.size() > 0);
    chk("st_ready", sbif.st_ready_o, e_ready);
    chk("empty", sbif.empty_o, q.size() == 0);
    chk("misalign", sbif.st_misalign_o, exp_mis);
    chk("ld_stall", sbif.ld_stall_o, lv && e_hit);
    chk("mem_load", sbif.mem_load_o, e_grant);
    chk("mem_store", sbif.mem_store_o, e_drain);
    if (e_grant) begin
      chk("ld_addr", sbif.mem_addr_o, la);
      chk("ld_funct3", sbif.mem_funct3_o, lf);
    end else if (e_drain) begin
      chk("st_addr", sbif.mem_addr_o, q[0].a);
      chk("st_wdata", sbif.mem_wdata_o, q[0].d);
      chk("st_funct3", sbif.mem_funct3_o, q[0].f);
    end else begin
      chk("idle_addr", sbif.mem_addr_o, 32'h0);
      chk("idle_wdata", sbif.mem_wdata_o, 32'h0);
      chk("idle_funct3", sbif.mem_funct3_o, 32'h0);
    end
    @(posedge clk);
    if (e_drain) void'(q.pop_front());
    if (sv && e_ready && e_legal) q.push_back('{sa, sd, sf});
    exp_mis = sv && e_ready && !e_legal;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 3'd0);
  endtask

  initial begin
    sbif.st_valid_i  = 1'b0;
    sbif.st_addr_i   = '0;
    sbif.st_data_i   = '0;
    sbif.st_funct3_i = '0;
    sbif.ld_valid_i  = 1'b0;
    sbif.ld_addr_i   = '0;
    sbif.ld_funct3_i = '0;

    // Reset state
    #3;
    chk("rst_ready", sbif.st_ready_o, 1'b1);
    chk("rst_empty", sbif.empty_o, 1'b1);
    chk("rst_store", sbif.mem_store_o, 1'b0);
    chk("rst_misalign", sbif.st_misalign_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single SW then drain
    step(1'b1, 32'h100, 32'hDEADBEEF, 3'd2, 1'b0, 32'h0, 3'd0);
    idle(2);

    // 2: five SB stores while an unrelated load holds the port
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h10 + 32'(i), 32'hA0 + 32'(i), 3'd0, 1'b1, 32'h200, 3'd2);
    step(1'b1, 32'h14, 32'hA4, 3'd0, 1'b0, 32'h0, 3'd0);
    step(1'b1, 32'h14, 32'hA4, 3'd0, 1'b0, 32'h0, 3'd0);
    idle(6);

    // 3: misaligned stores
    step(1'b1, 32'h101, 32'h1111, 3'd1, 1'b0, 32'h0, 3'd0);
    step(1'b1, 32'h102, 32'h2222, 3'd2, 1'b0, 32'h0, 3'd0);
    step(1'b1, 32'h104, 32'h3333, 3'd3, 1'b0, 32'h0, 3'd0);
    idle(2);

    // 4: load hazard on a pending word
    step(1'b1, 32'h40, 32'hCAFEF00D, 3'd2, 1'b1, 32'h300, 3'd2);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h42, 3'd2);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h42, 3'd2);
    idle(1);

    // 5: count held at 2 with simultaneous enqueue/drain, pointers wrap
    step(1'b1, 32'h80, 32'h80, 3'd2, 1'b1, 32'h400, 3'd2);
    step(1'b1, 32'h84, 32'h84, 3'd2, 1'b1, 32'h400, 3'd2);
    for (int i = 0; i < 8; i++)
      step(1'b1, 32'h88 + 32'(4 * i), 32'h1000 + 32'(i), 3'd2, 1'b0, 32'h0, 3'd0);
    idle(3);

    // 6: asynchronous reset mid-drain with 3 pending stores
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h500 + 32'(4 * i), 32'h77 + 32'(i), 3'd2, 1'b1, 32'h600, 3'd2);
    sbif.st_valid_i = 1'b0;
    sbif.ld_valid_i = 1'b0;
    #1;
    chk("pre_rst_store", sbif.mem_store_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_store", sbif.mem_store_o, 1'b0);
    chk("arst_empty", sbif.empty_o, 1'b1);
    chk("arst_ready", sbif.st_ready_o, 1'b1);
    q.delete();
    exp_mis = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(4);

    // Randomized traffic over a small address window to provoke hits
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] sa, la;
      logic [2:0]  sf;
      int          pick;
      sa   = 32'h40 + 32'($urandom_range(0, 31));
      la   = ($urandom_range(0, 7) == 0) ? 32'h900 : 32'h40 + 32'($urandom_range(0, 31));
      pick = $urandom_range(0, 9);
      sf   = (pick < 7) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), sa, $urandom, sf,
           1'($urandom_range(0, 2) == 0), la, 3'($urandom_range(0, 7)));
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
